neuron_sekvencer: RTL and testbench
===================================

NEURON_SEKVENCER -- requirements
Module: neuron_sekvencer

Interface
REQ-001 SHALL have parameter BROJ_ZNACAJKI, default 60: number of 16-bit features per sample.
REQ-002 SHALL have parameter SIRINA_SUME, default 22: width of the positive/negative accumulators and of suma.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to evaluate one sample.
REQ-006 SHALL have port uzorak, input, 16*BROJ_ZNACAJKI: sample; feature k occupies bits [16k+15:16k].
REQ-007 SHALL have port zauzet, output, 1: high while an evaluation is in progress.
REQ-008 SHALL have port tezina_adr, output, 6: weight ROM address equal to the current feature index.
REQ-009 SHALL have port tezina, input, 16: sign-magnitude weight from the combinational ROM for tezina_adr (bit 15 = sign, 1 = negative).
REQ-010 SHALL have port mn_tezina, output, 16: weight operand to the shared external mnozenje instance (tezina passed through).
REQ-011 SHALL have port mn_uzorak, output, 16: sample operand to mnozenje, the registered feature at tezina_adr.
REQ-012 SHALL have port mn_produkt, input, 16: unsigned product magnitude returned combinationally by mnozenje.
REQ-013 SHALL have port suma, output, SIRINA_SUME: registered |P - N| driven to Sigmoid_LUT.
REQ-014 SHALL have port predznak, output, 1: registered sign of P - N (1 = non-positive) driven to Sigmoid_LUT.
REQ-015 SHALL have port vjerojatnost, input, 16: combinational Sigmoid_LUT result for suma/predznak.
REQ-016 SHALL have port izlaz, output, 16: registered neuron output.
REQ-017 SHALL have port gotov, output, 1: one-cycle pulse when izlaz is updated.

Function
REQ-018 SHALL implement states MIRUJE, MAC, RAZLIKA, ZAPIS; MIRUJE after reset.
REQ-019 In MIRUJE with start=1, SHALL latch uzorak into an internal register, clear P and N, set index to 0, enter MAC; zauzet=1 from the next cycle.
REQ-020 In MAC each cycle SHALL add zero-extended mn_produkt to N if tezina[15]=1, else to P, then increment index.
REQ-021 SHALL leave MAC for RAZLIKA after the cycle with index = BROJ_ZNACAJKI-1 (exactly BROJ_ZNACAJKI MAC cycles).
REQ-022 Accumulators SHALL not saturate or wrap: 60 x 65535 < 2^22 by construction.
REQ-023 In RAZLIKA SHALL register suma=P-N, predznak=0 when P>N; else suma=N-P, predznak=1 (P=N gives suma=0, predznak=1); then enter ZAPIS.
REQ-024 In ZAPIS SHALL register izlaz<=vjerojatnost, pulse gotov for that single cycle, clear zauzet, and return to MIRUJE.
REQ-025 Latency SHALL be BROJ_ZNACAJKI+2 cycles from the start-accept edge to the edge where izlaz/gotov update (62 for the default).
REQ-026 start while zauzet=1 SHALL be ignored; the latched sample SHALL not change mid-evaluation.
REQ-027 start high in the same cycle gotov pulses SHALL be ignored; the next evaluation is accepted at the earliest one cycle later from MIRUJE.
REQ-028 izlaz, suma and predznak SHALL hold their values until overwritten by the next evaluation.
REQ-029 tezina_adr SHALL be 0 in MIRUJE, RAZLIKA and ZAPIS.

Reset
REQ-030 rst=1 SHALL immediately force state MIRUJE, index 0, P=N=0, suma=0, predznak=0, izlaz=0, gotov=0, zauzet=0, independent of clk.
REQ-031 rst asserted mid-evaluation SHALL abort it with no gotov pulse; the first start after rst deassertion SHALL run a full fresh evaluation.

Verification
REQ-032 All features 0x0100, all weights positive, product model = 0x0010 -> P=960, N=0, suma=960, predznak=0, gotov exactly 62 cycles after start.
REQ-033 Even-indexed weights negative, odd positive, constant product 0x0020 -> P=N=960, suma=0, predznak=1.
REQ-034 All weights negative, product 0xFFFF every cycle -> N=3932100, no wrap, suma=3932100, predznak=1.
REQ-035 start pulsed at cycles 5, 30 and at the gotov cycle -> one evaluation only, zauzet high for 62 cycles, a single gotov.
REQ-036 rst asserted at MAC cycle 20 -> all outputs zero asynchronously, no gotov; a new start then gives the golden result at +62 cycles.
REQ-037 Back-to-back random samples against a golden model of the parallel sum -> izlaz equal to the LUT value for the model's suma/predznak each time.

Source files
------------

// File: rtl/neuron_sekvencer.sv
// Sequential neuron: BROJ_ZNACAJKI MAC cycles through a shared external multiplier, then |P-N| and a sigmoid lookup.
// Latency: BROJ_ZNACAJKI+2 cycles from the start-accept edge to the izlaz/gotov update edge.
// Backpressure: none; start is ignored while busy and in the gotov cycle, and results hold until the next evaluation.
module neuron_sekvencer #(
    parameter int BROJ_ZNACAJKI = 60,
    parameter int SIRINA_SUME   = 22
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [16*BROJ_ZNACAJKI-1:0]  uzorak,
    output logic                         zauzet,
    output logic [5:0]                   tezina_adr,
    input  logic [15:0]                  tezina,
    output logic [15:0]                  mn_tezina,
    output logic [15:0]                  mn_uzorak,
    input  logic [15:0]                  mn_produkt,
    output logic [SIRINA_SUME-1:0]       suma,
    output logic                         predznak,
    input  logic [15:0]                  vjerojatnost,
    output logic [15:0]                  izlaz,
    output logic                         gotov
);

    typedef enum logic [1:0] {
        MIRUJE  = 2'd0,
        MAC     = 2'd1,
        RAZLIKA = 2'd2,
        ZAPIS   = 2'd3
    } stanje_t;

    localparam logic [5:0] ZADNJI = 6'(BROJ_ZNACAJKI - 1);

    stanje_t                r_stanje;
    stanje_t                w_sljedece;
    logic [5:0]             r_indeks;
    logic [15:0]            r_znacajke [BROJ_ZNACAJKI];
    logic [SIRINA_SUME-1:0] r_poz;
    logic [SIRINA_SUME-1:0] r_neg;
    logic [SIRINA_SUME-1:0] r_suma;
    logic                   r_predznak;
    logic [15:0]            r_izlaz;
    logic                   r_gotov;

    logic                   w_prihvat;
    logic                   w_zadnji;
    logic [5:0]             w_adr;
    logic [SIRINA_SUME-1:0] w_produkt;

    // A start in the gotov cycle must be dropped, so acceptance also requires gotov low.
    assign w_prihvat = (r_stanje == MIRUJE) && start && !r_gotov;
    assign w_zadnji  = (r_indeks == ZADNJI);
    assign w_produkt = {{(SIRINA_SUME-16){1'b0}}, mn_produkt};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stanje <= MIRUJE;
        end else begin
            r_stanje <= w_sljedece;
        end
    end

    // Next-state logic
    always_comb begin
        w_sljedece = r_stanje;
        case (r_stanje)
            MIRUJE:  if (w_prihvat) w_sljedece = MAC;
            MAC:     if (w_zadnji)  w_sljedece = RAZLIKA;
            RAZLIKA: w_sljedece = ZAPIS;
            ZAPIS:   w_sljedece = MIRUJE;
            default: w_sljedece = MIRUJE;
        endcase
    end

    // State-decoded outputs: busy flag and ROM address (address parked at 0 outside MAC)
    always_comb begin
        zauzet = (r_stanje != MIRUJE);
        w_adr  = '0;
        if (r_stanje == MAC) begin
            w_adr = r_indeks;
        end
    end

    assign tezina_adr = w_adr;
    assign mn_tezina  = tezina;
    assign mn_uzorak  = r_znacajke[w_adr];

    // Sample latch: only written on acceptance, so input changes mid-evaluation are invisible
    always_ff @(posedge clk) begin
        if (w_prihvat) begin
            for (int k = 0; k < BROJ_ZNACAJKI; k++) begin
                r_znacajke[k] <= uzorak[16*k +: 16];
            end
        end
    end

    // Datapath: sign-split accumulation, magnitude/sign of the difference, result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_indeks   <= '0;
            r_poz      <= '0;
            r_neg      <= '0;
            r_suma     <= '0;
            r_predznak <= 1'b0;
            r_izlaz    <= '0;
            r_gotov    <= 1'b0;
        end else begin
            r_gotov <= 1'b0;
            case (r_stanje)
                MIRUJE: begin
                    if (w_prihvat) begin
                        r_indeks <= '0;
                        r_poz    <= '0;
                        r_neg    <= '0;
                    end
                end
                MAC: begin
                    // Accumulators are sized so the sum of all products cannot overflow.
                    if (tezina[15]) begin
                        r_neg <= r_neg + w_produkt;
                    end else begin
                        r_poz <= r_poz + w_produkt;
                    end
                    r_indeks <= w_zadnji ? '0 : r_indeks + 6'd1;
                end
                RAZLIKA: begin
                    // Equal sums report as non-positive (predznak=1, suma=0).
                    if (r_poz > r_neg) begin
                        r_suma     <= r_poz - r_neg;
                        r_predznak <= 1'b0;
                    end else begin
                        r_suma     <= r_neg - r_poz;
                        r_predznak <= 1'b1;
                    end
                end
                ZAPIS: begin
                    r_izlaz <= vjerojatnost;
                    r_gotov <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign suma     = r_suma;
    assign predznak = r_predznak;
    assign izlaz    = r_izlaz;
    assign gotov    = r_gotov;

endmodule

// File: tb/tb_neuron_sekvencer.sv
// Bench for neuron_sekvencer: external weight ROM, multiplier and sigmoid LUT are modelled here.
// Expected sums come from a direct summation over the sample, not from cycle behaviour.
// Randomized back-to-back samples plus the directed corner cases.
module tb_neuron_sekvencer;

    localparam int BZ = 60;
    localparam int SS = 22;

    logic            clk;
    logic            rst;
    logic            start;
    logic [16*BZ-1:0] uzorak;
    logic            zauzet;
    logic [5:0]      tezina_adr;
    logic [15:0]     tezina;
    logic [15:0]     mn_tezina;
    logic [15:0]     mn_uzorak;
    logic [15:0]     mn_produkt;
    logic [SS-1:0]   suma;
    logic            predznak;
    logic [15:0]     vjerojatnost;
    logic [15:0]     izlaz;
    logic            gotov;

    logic [15:0]     rom [64];
    logic            mnoz_pravi;
    logic [15:0]     konst;
    logic [16*BZ-1:0] uz_tren;

    int n_provjera;
    int n_gresaka;

    neuron_sekvencer #(.BROJ_ZNACAJKI(BZ), .SIRINA_SUME(SS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .uzorak       (uzorak),
        .zauzet       (zauzet),
        .tezina_adr   (tezina_adr),
        .tezina       (tezina),
        .mn_tezina    (mn_tezina),
        .mn_uzorak    (mn_uzorak),
        .mn_produkt   (mn_produkt),
        .suma         (suma),
        .predznak     (predznak),
        .vjerojatnost (vjerojatnost),
        .izlaz        (izlaz),
        .gotov        (gotov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational blocks: weight ROM, multiplier (constant or Q15), sigmoid LUT
    always_comb begin
        tezina = rom[tezina_adr];
        if (mnoz_pravi) mn_produkt = 16'((32'(mn_tezina[14:0]) * 32'(mn_uzorak)) >> 15);
        else            mn_produkt = konst;
        vjerojatnost = {predznak, suma[14:0] ^ suma[21:7]};
    end

    function automatic logic [15:0] lut(input logic [21:0] s, input logic p);
        return {p, s[14:0] ^ s[21:7]};
    endfunction

    function automatic logic [15:0] mnozi(input logic [15:0] w, input logic [15:0] f);
        if (mnoz_pravi) return 16'((32'(w[14:0]) * 32'(f)) >> 15);
        return konst;
    endfunction

    // Reference: whole-sample signed sum split into magnitude and sign
    function automatic void model(input logic [16*BZ-1:0] s, output logic [21:0] es, output logic ep);
        longint p = 0;
        longint n = 0;
        for (int k = 0; k < BZ; k++) begin
            logic [15:0] f;
            logic [15:0] w;
            f = s[16*k +: 16];
            w = rom[k];
            if (w[15]) n += longint'(mnozi(w, f));
            else       p += longint'(mnozi(w, f));
        end
        if (p > n) begin es = 22'(p - n); ep = 1'b0; end
        else       begin es = 22'(n - p); ep = 1'b1; end
    endfunction

    function automatic logic [16*BZ-1:0] nasumicni();
        logic [16*BZ-1:0] r;
        for (int k = 0; k < BZ; k++) r[16*k +: 16] = 16'($urandom);
        return r;
    endfunction

    task automatic provjeri(input string tag, input logic [31:0] dobiveno, input logic [31:0] ocekivano);
        n_provjera++;
        if (dobiveno !== ocekivano) begin
            n_gresaka++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, dobiveno, dobiveno, ocekivano, ocekivano);
        end
    endtask

    // One evaluation of uz_tren; called at a negedge. ometaj adds stray starts; lanac leaves start
    // high through the gotov cycle so the next call is accepted at the earliest legal edge.
    task automatic izvrsi(input string ime, input bit ometaj, input bit lanac);
        logic [21:0] es;
        logic        ep;
        int          lat;
        int          busy;
        model(uz_tren, es, ep);
        uzorak = uz_tren;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        uzorak = nasumicni();
        lat  = -1;
        busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = ometaj && (i == 5 || i == 30);
            if (zauzet) busy++;
            if (i == 10) begin
                provjeri({ime, " adr@10"}, 32'(tezina_adr), 32'd10);
                provjeri({ime, " mn_uzorak@10"}, 32'(mn_uzorak), 32'(uz_tren[16*10 +: 16]));
            end
            if (i == 60) provjeri({ime, " adr@razlika"}, 32'(tezina_adr), 32'd0);
            if (gotov) begin
                lat = i;
                break;
            end
        end
        provjeri({ime, " latency"}, 32'(lat), 32'd62);
        provjeri({ime, " busy cycles"}, 32'(busy), 32'd62);
        provjeri({ime, " suma"}, 32'(suma), 32'(es));
        provjeri({ime, " predznak"}, 32'(predznak), 32'(ep));
        provjeri({ime, " izlaz"}, 32'(izlaz), 32'(lut(es, ep)));
        start  = lanac | ometaj;
        uzorak = nasumicni();
        @(negedge clk);
        provjeri({ime, " start in gotov cycle ignored"}, 32'(zauzet), 32'd0);
        provjeri({ime, " single gotov"}, 32'(gotov), 32'd0);
        if (!lanac) start = 1'b0;
    endtask

    task automatic cfg_pozitivno();
        for (int k = 0; k < 64; k++) rom[k] = 16'h0001;
        mnoz_pravi = 1'b0;
        konst = 16'h0010;
        for (int k = 0; k < BZ; k++) uz_tren[16*k +: 16] = 16'h0100;
    endtask

    initial begin
        int gotovi;
        n_provjera = 0;
        n_gresaka  = 0;
        rst = 1'b0;
        start = 1'b0;
        uzorak = '0;
        cfg_pozitivno();
        #2 rst = 1'b1;
        #1;
        provjeri("reset zauzet", 32'(zauzet), 32'd0);
        provjeri("reset gotov", 32'(gotov), 32'd0);
        provjeri("reset suma", 32'(suma), 32'd0);
        provjeri("reset predznak", 32'(predznak), 32'd0);
        provjeri("reset izlaz", 32'(izlaz), 32'd0);
        provjeri("reset adr", 32'(tezina_adr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All positive: P=960
        izvrsi("pos", 1'b0, 1'b0);
        provjeri("pos suma const", 32'(suma), 32'd960);

        // Alternating sign: P=N=960
        for (int k = 0; k < 64; k++) rom[k] = (k % 2 == 0) ? 16'h8001 : 16'h0001;
        konst = 16'h0020;
        izvrsi("eq", 1'b0, 1'b0);
        provjeri("eq predznak const", 32'(predznak), 32'd1);

        // All negative, maximal product: no wrap
        for (int k = 0; k < 64; k++) rom[k] = 16'h8000 | 16'($urandom_range(0, 32767));
        konst = 16'hFFFF;
        izvrsi("maxneg", 1'b0, 1'b0);
        provjeri("maxneg suma const", 32'(suma), 32'd3932100);

        // Stray starts mid-evaluation and in the gotov cycle
        cfg_pozitivno();
        izvrsi("stray", 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        provjeri("stray no restart", 32'(zauzet), 32'd0);

        // Reset during MAC
        uzorak = uz_tren;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        provjeri("abort zauzet", 32'(zauzet), 32'd0);
        provjeri("abort suma", 32'(suma), 32'd0);
        provjeri("abort predznak", 32'(predznak), 32'd0);
        provjeri("abort izlaz", 32'(izlaz), 32'd0);
        provjeri("abort gotov", 32'(gotov), 32'd0);
        provjeri("abort adr", 32'(tezina_adr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        gotovi = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (gotov) gotovi++;
        end
        provjeri("abort no gotov", 32'(gotovi), 32'd0);
        izvrsi("after abort", 1'b0, 1'b0);

        // Random back-to-back samples with a real multiplier
        mnoz_pravi = 1'b1;
        for (int k = 0; k < 64; k++) rom[k] = 16'($urandom);
        for (int t = 0; t < 8; t++) begin
            uz_tren = nasumicni();
            izvrsi($sformatf("rnd%0d", t), 1'b0, t != 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_provjera, n_gresaka);
        $finish;
    end

endmodule
